// File: rtl/hram_pkg.sv
`default_nettype none
// ============================================================================
// hram_pkg : shared types and CA-word packing for the HyperRAM Avalon bridge
// Rev 1.0
// ============================================================================
package hram_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_WBEAT0 = 3'd2,
    S_WBEAT1 = 3'd3,
    S_RBEAT0 = 3'd4,
    S_RBEAT1 = 3'd5,
    S_RESP   = 3'd6
  } state_t;

  localparam int CA_RW = 47;
  localparam int CA_AS = 46;
  localparam int CA_BT = 45;

  localparam logic [31:0] READ_ERR_DATA = 32'hDEADBEEF;

  // Linear-burst memory-space CA word from a halfword address.
  function automatic logic [47:0] ca_pack(input logic rw, input logic [31:0] ha);
    logic [47:0] ca;
    ca          = '0;
    ca[CA_RW]   = rw;
    ca[CA_AS]   = 1'b0;
    ca[CA_BT]   = 1'b1;
    ca[44:16]   = ha[31:3];
    ca[2:0]     = ha[2:0];
    return ca;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hram_avalon_bridge.sv
`default_nettype none
// ============================================================================
// hram_avalon_bridge : single-beat 32-bit Avalon-MM slave to HyperRAM CA/beat streams
// Rev 1.0
// ============================================================================
module hram_avalon_bridge
  import hram_pkg::*;
#(
  parameter int ADDR_W  = 22,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic              avs_waitrequest,
  output logic [31:0]       avs_readdata,
  output logic              avs_readdatavalid,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [47:0]       cmd_ca,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [15:0]       wr_data,
  output logic [1:0]        wr_mask,
  input  logic              rd_valid,
  input  logic [15:0]       rd_data,
  output logic              err
);

  localparam int              CNT_W      = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_next;
  logic [47:0]      r_ca;
  logic [31:0]      r_wd;
  logic [3:0]       r_be;
  logic             r_is_wr;
  logic [15:0]      r_lo;
  logic [31:0]      r_rdata;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  logic [31:0]      w_ha;
  logic             w_accept;
  logic             w_in_rbeat;
  logic             w_timeout;

  assign w_ha       = {{(31 - ADDR_W){1'b0}}, avs_address, 1'b0};
  assign w_accept   = (r_state == S_IDLE) && (avs_read || avs_write);
  assign w_in_rbeat = (r_state == S_RBEAT0) || (r_state == S_RBEAT1);
  assign w_timeout  = w_in_rbeat && !rd_valid && (r_cnt == C_CNT_LAST);

  assign cmd_ca       = r_ca;
  assign avs_readdata = r_rdata;
  assign err          = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next            = r_state;
    // Stall is also forced while reset is held, since the state alone reads IDLE then.
    avs_waitrequest   = rst || (r_state != S_IDLE);
    avs_readdatavalid = 1'b0;
    cmd_valid         = 1'b0;
    wr_valid          = 1'b0;
    wr_data           = '0;
    wr_mask           = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_CMD;
      end
      S_CMD: begin
        cmd_valid = 1'b1;
        if (cmd_ready) w_next = r_is_wr ? S_WBEAT0 : S_RBEAT0;
      end
      S_WBEAT0: begin
        wr_valid = 1'b1;
        wr_data  = r_wd[15:0];
        wr_mask  = ~r_be[1:0];
        if (wr_ready) w_next = S_WBEAT1;
      end
      S_WBEAT1: begin
        wr_valid = 1'b1;
        wr_data  = r_wd[31:16];
        wr_mask  = ~r_be[3:2];
        if (wr_ready) w_next = S_IDLE;
      end
      S_RBEAT0: begin
        if (rd_valid)       w_next = S_RBEAT1;
        else if (w_timeout) w_next = S_RESP;
      end
      S_RBEAT1: begin
        if (rd_valid || w_timeout) w_next = S_RESP;
      end
      S_RESP: begin
        avs_readdatavalid = 1'b1;
        w_next            = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ca    <= '0;
      r_wd    <= '0;
      r_be    <= '0;
      r_is_wr <= 1'b0;
      r_lo    <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      // Simultaneous read+write resolves to a write.
      if (w_accept) begin
        r_ca    <= ca_pack(!avs_write, w_ha);
        r_wd    <= avs_writedata;
        r_be    <= avs_byteenable;
        r_is_wr <= avs_write;
      end

      if (!w_in_rbeat || rd_valid || w_timeout) r_cnt <= '0;
      else                                      r_cnt <= r_cnt + CNT_W'(1);

      if ((r_state == S_RBEAT0) && rd_valid) r_lo <= rd_data;

      // Readdata only changes at response time so it holds between reads.
      if ((r_state == S_RBEAT1) && rd_valid) begin
        r_rdata <= {rd_data, r_lo};
      end else if (w_timeout) begin
        r_rdata <= READ_ERR_DATA;
        r_err   <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hram_avalon_bridge.sv
`default_nettype none
// ============================================================================
// tb_hram_avalon_bridge : randomized self-checking bench for hram_avalon_bridge
// Rev 1.0
// ============================================================================
module tb_hram_avalon_bridge;

  localparam int AW  = 22;
  localparam int TMO = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] avs_address = '0;
  logic          avs_read = 1'b0;
  logic          avs_write = 1'b0;
  logic [31:0]   avs_writedata = '0;
  logic [3:0]    avs_byteenable = '0;
  logic          avs_waitrequest;
  logic [31:0]   avs_readdata;
  logic          avs_readdatavalid;
  logic          cmd_valid;
  logic          cmd_ready = 1'b0;
  logic [47:0]   cmd_ca;
  logic          wr_valid;
  logic          wr_ready = 1'b0;
  logic [15:0]   wr_data;
  logic [1:0]    wr_mask;
  logic          rd_valid = 1'b0;
  logic [15:0]   rd_data = '0;
  logic          err;

  int n_total = 0;
  int n_bad   = 0;
  logic exp_err = 1'b0;

  always #5 clk = ~clk;

  hram_avalon_bridge #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_waitrequest(avs_waitrequest), .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ca(cmd_ca),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_mask(wr_mask),
    .rd_valid(rd_valid), .rd_data(rd_data), .err(err)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference CA word from plain arithmetic on the word address.
  function automatic logic [47:0] exp_ca(input bit rd, input logic [AW-1:0] a);
    logic [47:0] ha;
    ha = 48'(a) * 48'd2;
    return (rd ? 48'h8000_0000_0000 : 48'h0) + 48'h2000_0000_0000
           + ((ha / 48'd8) << 16) + (ha % 48'd8);
  endfunction

  task automatic do_accept(input bit rd, input bit wr, input logic [AW-1:0] a,
                           input logic [31:0] wd, input logic [3:0] be);
    check_eq("idle_waitreq", 64'(avs_waitrequest), 64'(0));
    avs_address    = a;
    avs_read       = rd;
    avs_write      = wr;
    avs_writedata  = wd;
    avs_byteenable = be;
    @(negedge clk);
    avs_read  = 1'b0;
    avs_write = 1'b0;
    avs_writedata = $urandom;
  endtask

  task automatic cmd_phase(input logic [47:0] ca, input int stall, inout int nwait);
    for (int i = 0; i <= stall; i++) begin
      check_eq("cmd_valid", 64'(cmd_valid), 64'(1));
      check_eq("cmd_ca", 64'(cmd_ca), 64'(ca));
      check_eq("cmd_no_wr", 64'(wr_valid), 64'(0));
      if (avs_waitrequest) nwait++;
      cmd_ready = (i == stall);
      @(negedge clk);
    end
    cmd_ready = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] wd, input logic [3:0] be,
                          input int cs, input int ws, input bit both);
    int nwait;
    logic [15:0] hw;
    logic [3:0]  nbe;
    nwait = 0;
    nbe   = ~be;
    do_accept(both, 1'b1, a, wd, be);
    cmd_phase(exp_ca(1'b0, a), cs, nwait);
    for (int b = 0; b < 2; b++) begin
      hw = (b == 0) ? wd[15:0] : wd[31:16];
      for (int j = 0; j <= ws; j++) begin
        check_eq("wr_valid", 64'(wr_valid), 64'(1));
        check_eq("wr_data", 64'(wr_data), 64'(hw));
        check_eq("wr_mask", 64'(wr_mask), 64'((b == 0) ? nbe[1:0] : nbe[3:2]));
        check_eq("wr_no_cmd", 64'(cmd_valid), 64'(0));
        if (avs_waitrequest) nwait++;
        wr_ready = (j == ws);
        @(negedge clk);
      end
    end
    wr_ready = 1'b0;
    check_eq("wr_stall_cycles", 64'(nwait), 64'(cs + 1 + 2 * (ws + 1)));
    check_eq("wr_done_idle", 64'(avs_waitrequest), 64'(0));
    check_eq("wr_no_rdv", 64'(avs_readdatavalid), 64'(0));
    check_eq("wr_valid_off", 64'(wr_valid), 64'(0));
  endtask

  task automatic rd_beat(input logic [15:0] d, input int dly);
    for (int j = 0; j <= dly; j++) begin
      check_eq("rd_no_rdv", 64'(avs_readdatavalid), 64'(0));
      check_eq("rd_no_wr", 64'(wr_valid), 64'(0));
      rd_valid = (j == dly);
      rd_data  = (j == dly) ? d : 16'($urandom);
      @(negedge clk);
    end
    rd_valid = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [15:0] d0, input logic [15:0] d1,
                         input int dl0, input int dl1, input int cs);
    int nwait;
    nwait = 0;
    do_accept(1'b1, 1'b0, a, 32'h0, 4'h0);
    cmd_phase(exp_ca(1'b1, a), cs, nwait);
    rd_beat(d0, dl0);
    rd_beat(d1, dl1);
    check_eq("rd_rdv", 64'(avs_readdatavalid), 64'(1));
    check_eq("rd_data", 64'(avs_readdata), 64'({d1, d0}));
    check_eq("rd_err", 64'(err), 64'(exp_err));
    @(negedge clk);
    check_eq("rd_rdv_once", 64'(avs_readdatavalid), 64'(0));
    check_eq("rd_data_hold", 64'(avs_readdata), 64'({d1, d0}));
    check_eq("rd_back_idle", 64'(avs_waitrequest), 64'(0));
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_waitreq", 64'(avs_waitrequest), 64'(1));
    check_eq("rst_rdv", 64'(avs_readdatavalid), 64'(0));
    check_eq("rst_rdata", 64'(avs_readdata), 64'(0));
    check_eq("rst_cmd_valid", 64'(cmd_valid), 64'(0));
    check_eq("rst_cmd_ca", 64'(cmd_ca), 64'(0));
    check_eq("rst_wr_valid", 64'(wr_valid), 64'(0));
    check_eq("rst_wr_data", 64'(wr_data), 64'(0));
    check_eq("rst_wr_mask", 64'(wr_mask), 64'(0));
    check_eq("rst_err", 64'(err), 64'(0));
  endtask

  initial begin : main
    int nwait;
    int k;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    @(negedge clk);

    do_write(22'h000010, 32'hA1B2C3D4, 4'hF, 0, 0, 1'b0);
    do_read(22'h000003, 16'h1234, 16'h5678, 0, 0, 0);
    do_write(22'h00ABCD, 32'h55AA_33CC, 4'b0101, 0, 0, 1'b0);
    do_write(22'h000777, 32'h0BAD_F00D, 4'b1001, 5, 0, 1'b0);
    do_write(22'h012345, 32'hCAFE_0001, 4'b1110, 0, 2, 1'b1);
    do_write(22'h3FFFFF, 32'hFFFF_0000, 4'hF, 0, 0, 1'b0);
    do_read(22'h3FFFFF, 16'hBEEF, 16'hF00D, 3, 1, 2);

    // Stray read beats while idle must be ignored.
    for (int i = 0; i < 3; i++) begin
      rd_valid = 1'b1;
      rd_data  = 16'hDEAD;
      @(negedge clk);
      check_eq("stray_rdv", 64'(avs_readdatavalid), 64'(0));
      check_eq("stray_idle", 64'(avs_waitrequest), 64'(0));
    end
    rd_valid = 1'b0;
    do_read(22'h000100, 16'h0F0F, 16'hA5A5, 1, 0, 0);

    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(1, 0) == 1)
        do_write(AW'($urandom), $urandom, 4'($urandom), $urandom_range(3, 0),
                 $urandom_range(3, 0), 1'($urandom));
      else
        do_read(AW'($urandom), 16'($urandom), 16'($urandom), $urandom_range(TMO - 2, 0),
                $urandom_range(TMO - 2, 0), $urandom_range(3, 0));
    end

    // Read that never gets a beat.
    nwait = 0;
    do_accept(1'b1, 1'b0, 22'h000040, 32'h0, 4'h0);
    cmd_phase(exp_ca(1'b1, 22'h000040), 0, nwait);
    k = 0;
    while (!avs_readdatavalid && k < 40) begin
      @(negedge clk);
      k++;
    end
    exp_err = 1'b1;
    check_eq("tmo_cycles", 64'(k), 64'(TMO));
    check_eq("tmo_rdata", 64'(avs_readdata), 64'(32'hDEADBEEF));
    check_eq("tmo_err", 64'(err), 64'(1));
    @(negedge clk);
    check_eq("tmo_rdv_once", 64'(avs_readdatavalid), 64'(0));
    do_read(22'h000041, 16'h1111, 16'h2222, 2, 2, 0);

    // Reset while the second write beat is stalled.
    nwait = 0;
    do_accept(1'b0, 1'b1, 22'h000020, 32'h89AB_CDEF, 4'hF);
    cmd_phase(exp_ca(1'b0, 22'h000020), 0, nwait);
    wr_ready = 1'b1;
    @(negedge clk);
    wr_ready = 1'b0;
    check_eq("pre_rst_wbeat1", 64'(wr_data), 64'(16'h89AB));
    rst = 1'b1;
    #1;
    exp_err = 1'b0;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_read(22'h000005, 16'h3C3C, 16'hC3C3, 0, 4, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hram_avalon_bridge.md
Name: hram_avalon_bridge

Overview:
Avalon-MM slave front-end for the HyperRAM controller; it sits directly upstream of the top_stm sequencer and takes the place of the direct master connection. Each single-beat 32-bit Avalon read or write becomes one HyperRAM transaction: one 48-bit CA command plus two 16-bit data beats. Write beats go out on a valid/ready stream. Read beats come back on a valid stream and are reassembled into one 32-bit readdatavalid response.

Parameters:
ADDR_W, 22, Avalon word-address width (32-bit words); 22 gives 16 MiB.
TIMEOUT, 1023, max cycles to wait for each read beat before an error response.

Ports:
clk  in  1  system clock (clk0 domain)
rst  in  1  asynchronous reset, active-high
avs_address  in  ADDR_W  word address
avs_read  in  1  read request
avs_write  in  1  write request
avs_writedata  in  32  write data
avs_byteenable  in  4  byte enables
avs_waitrequest  out  1  stall
avs_readdata  out  32  read data
avs_readdatavalid  out  1  read response strobe
cmd_valid  out  1  CA command valid
cmd_ready  in  1  sequencer accepts command
cmd_ca  out  48  HyperRAM CA word
wr_valid  out  1  write beat valid
wr_ready  in  1  sequencer consumes write beat
wr_data  out  16  write beat
wr_mask  out  2  RWDS mask, 1 = byte masked
rd_valid  in  1  read beat strobe from sequencer
rd_data  in  16  read beat
err  out  1  sticky timeout flag

Behaviour:
- Reset: all outputs are 0, with one exception: avs_waitrequest is 1. State is IDLE and the timeout counter is 0. Reset asserted mid-transaction aborts immediately with no response, and err is cleared.
- States: IDLE, CMD, WBEAT0, WBEAT1, RBEAT0, RBEAT1, RESP.
- IDLE:
  - avs_waitrequest = 0 (combinational on state), so a request is accepted in the same cycle that avs_read or avs_write is high.
  - On accept, capture address, writedata and byteenable, then go to CMD.
  - If avs_read and avs_write are high together, treat it as a write.
- Address: halfword address ha = {avs_address, 1'b0}, zero-extended to 32 bits.
- CA fields:
  - [47] = 1 for read, 0 for write
  - [46] = 0 (memory space)
  - [45] = 1 (linear burst)
  - [44:16] = ha[31:3]
  - [15:3] = 0
  - [2:0] = ha[2:0]
- CMD: cmd_valid = 1 with cmd_ca held stable until cmd_ready. Handshake cycle goes to WBEAT0 (write) or RBEAT0 (read).
- WBEAT0:
  - wr_valid = 1, wr_data = wd[15:0], wr_mask = ~be[1:0].
  - On wr_ready go to WBEAT1.
- WBEAT1:
  - wr_data = wd[31:16], wr_mask = ~be[3:2].
  - On wr_ready go to IDLE.
  - Writes produce no Avalon response.
- RBEAT0: on rd_valid, latch rd_data into readdata[15:0] and go to RBEAT1.
- RBEAT1: on rd_valid, latch rd_data into readdata[31:16] and go to RESP.
- rd_valid outside RBEAT0/RBEAT1 is ignored.
- RESP: avs_readdatavalid = 1 for exactly one cycle with avs_readdata valid, then IDLE. avs_readdata holds its value until the next read's response.
- Latency:
  - Read, with cmd_ready constant 1 and rd_valid arriving N cycles after the command handshake: readdatavalid follows 1 cycle after the second beat.
  - Write, with ready constant 1: 3 cycles from accept to IDLE.
- Timeout:
  - The counter runs in RBEAT0/RBEAT1 and clears on each rd_valid.
  - On reaching TIMEOUT: go to RESP with avs_readdata = 32'hDEADBEEF, and set err.
  - err stays set until reset.
  - There is no timeout on cmd_ready or wr_ready.
- Address wrap: the top address (all ones) encodes as-is; there is no overflow.
- Only one transaction is ever outstanding.

Decomposition:
- Package hram_pkg holds:
  - state enum
  - CA bit-position localparams (CA_RW=47, CA_AS=46, CA_BT=45)
  - READ_ERR_DATA = 32'hDEADBEEF
  - function ca_pack(rw, ha) returning 48 bits
- No sub-module; the timeout counter and FSM live in one module.

Test Plan:
- Write: address 0x000010, writedata 0xA1B2C3D4, byteenable 4'hF, readies tied 1 -> cmd_ca = 48'h2000_0000_0000 | (0x20>>3)<<16 = 0x2000_0004_0000; beats 0xC3D4 mask 00, then 0xA1B2 mask 00; waitrequest high for 3 cycles.
- Read: address 0x000003 (ha=6) -> cmd_ca = 0xA000_0000_0006; rd_data 0x1234 then 0x5678 -> one readdatavalid with readdata 0x5678_1234.
- Byte-enable 4'b0101 write -> wr_mask 2'b10 then 2'b10.
- cmd_ready low for 5 cycles -> cmd_valid and cmd_ca stable throughout; wr_valid not asserted before the handshake.
- Read with no rd_valid, TIMEOUT=15 -> after 15 cycles in RBEAT0, readdatavalid with 0xDEADBEEF, err = 1 and stays 1 across the next good read.
- rst asserted during WBEAT1 -> all outputs return to reset values; the next read completes normally.
